// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// if_fetch_unit_if: instruction-memory request/response bus between fetch stage and imem.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (output req, output addr, input gnt, input rsp_valid, input rsp_data);
  modport slave  (input req, input addr, output gnt, output rsp_valid, output rsp_data);
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// if_fetch_unit: IF stage owning the PC, up to two in-flight word fetches,
// a 2-entry {pc, inst} FIFO and EX redirect handling. Revision 1.0.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  if_fetch_unit_if.master imem,
  output logic            out_valid,
  output logic [31:0]     out_pc,
  output logic [31:0]     out_inst
);

  logic [31:0] pc_q;
  logic [1:0]  inflight;
  logic [1:0]  discard;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];

  logic        pop;
  logic        push;
  logic        grant;
  logic [1:0]  live;
  logic [2:0]  claims;
  logic [31:0] rsp_pc;
  logic        unused_lsbs;

  assign unused_lsbs = ^redirect_pc[1:0];

  assign out_valid = (count != 2'd0);
  assign out_pc    = out_valid ? fifo_pc[rd_ptr]   : 32'h0;
  assign out_inst  = out_valid ? fifo_inst[rd_ptr] : NOP_INST;

  assign pop    = out_valid && !stall && !redirect_valid;
  assign live   = inflight - discard;
  // Buffered plus live in-flight entries must leave room for a new fetch.
  assign claims = {1'b0, count} + {1'b0, live};

  assign imem.req  = reset_n && !redirect_valid
                   && (claims < (3'd2 + {2'b00, pop}))
                   && ({1'b0, inflight} < (3'd2 + {2'b00, imem.rsp_valid}));
  assign imem.addr = pc_q;
  assign grant     = imem.req && imem.gnt;

  assign push   = imem.rsp_valid && (discard == 2'd0) && !redirect_valid;
  // Fetches are sequential, so the oldest live fetch sits live words behind pc_q.
  assign rsp_pc = pc_q - {28'h0, live, 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      inflight <= 2'd0;
      discard  <= 2'd0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else if (redirect_valid) begin
      pc_q     <= {redirect_pc[31:2], 2'b00};
      inflight <= inflight - {1'b0, imem.rsp_valid};
      discard  <= inflight - {1'b0, imem.rsp_valid};
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      if (grant) begin
        pc_q <= pc_q + 32'd4;
      end
      inflight <= inflight + {1'b0, grant} - {1'b0, imem.rsp_valid};
      if (imem.rsp_valid && (discard != 2'd0)) begin
        discard <= discard - 2'd1;
      end
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= rsp_pc;
      fifo_inst[wr_ptr] <= imem.rsp_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (count == 2'd2)));
  a_inflight_max: assert property (@(posedge clk) disable iff (!reset_n)
    (inflight <= 2'd2) && (discard <= inflight));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// tb_if_fetch_unit: directed self-checking bench with a fixed-latency in-order imem model.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int n_cmp = 0;
  int n_fail = 0;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem          (imem_bus),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_inst      (out_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // Memory model: always grants, answers in order lat cycles after the grant.
  int          lat = 1;
  int          cyc = 0;
  int          inflight_model = 0;
  logic [31:0] qa [$];
  int          qd [$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset_n) begin
      qa.delete();
      qd.delete();
    end
    inflight_model = qa.size();
    if (reset_n && (qa.size() > 0) && (qd[0] <= cyc)) begin
      imem_bus.rsp_valid = 1'b1;
      imem_bus.rsp_data  = inst_of(qa[0]);
    end else begin
      imem_bus.rsp_valid = 1'b0;
      imem_bus.rsp_data  = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (imem_bus.rsp_valid) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (imem_bus.req && imem_bus.gnt) begin
        qa.push_back(imem_bus.addr);
        qd.push_back(cyc + lat);
      end
    end
  end

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; lat = l;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; lat = 1;
    repeat (2) @(posedge clk);
    mid;
    n_cmp++; if (imem_bus.req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", imem_bus.req); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 0", out_pc); end
    n_cmp++; if (out_inst !== NOP) begin n_fail++; $display("FAIL rst_inst: got %h expected %h", out_inst, NOP); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    mid;
    n_cmp++; if (imem_bus.req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", imem_bus.req); end
    n_cmp++; if (imem_bus.addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h expected 0", imem_bus.addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_stream;
    logic [5:0] ev = 6'b111100;
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cyc;
      mid;
      n_cmp++; if (out_valid !== ev[k]) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected %b", k, out_valid, ev[k]); end
      if (ev[k]) begin
        n_cmp++; if (out_pc !== 32'(4 * (k - 2))) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, out_pc, 32'(4 * (k - 2))); end
        n_cmp++; if (out_inst !== inst_of(32'(4 * (k - 2)))) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h expected %h", k, out_inst, inst_of(32'(4 * (k - 2)))); end
      end
    end
  endtask

  task automatic test_stall;
    do_reset(1);
    repeat (4) next_cyc;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid;
      n_cmp++; if (out_pc !== 32'h8 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_head[%0d]: got %b/%h expected 1/00000008", i, out_valid, out_pc); end
      n_cmp++; if (imem_bus.req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_bus.req); end
      next_cyc;
    end
    stall = 1'b0;
    mid;
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h10) begin n_fail++; $display("FAIL release_req: got %b/%h expected 1/00000010", imem_bus.req, imem_bus.addr); end
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin next_cyc; mid; end
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(8 + 4 * j)) begin n_fail++; $display("FAIL release_pc[%0d]: got %b/%h expected 1/%h", j, out_valid, out_pc, 32'(8 + 4 * j)); end
    end
  endtask

  task automatic test_latency;
    logic [15:0] lv = 16'h3330;
    logic [31:0] nxt = 32'h0;
    int seen = 0;
    do_reset(3);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) next_cyc;
      mid;
      n_cmp++; if (out_valid !== lv[k]) begin n_fail++; $display("FAIL lat_valid[%0d]: got %b expected %b", k, out_valid, lv[k]); end
      if (lv[k]) begin
        n_cmp++; if (out_pc !== nxt) begin n_fail++; $display("FAIL lat_pc[%0d]: got %h expected %h", k, out_pc, nxt); end
        nxt = nxt + 32'd4;
      end
      if (out_valid === 1'b1) seen++;
      if ((inflight_model - int'(imem_bus.rsp_valid)) >= 2) begin
        n_cmp++; if (imem_bus.req !== 1'b0) begin n_fail++; $display("FAIL lat_req_full[%0d]: got %b expected 0", k, imem_bus.req); end
      end
    end
    n_cmp++; if (seen != 6) begin n_fail++; $display("FAIL lat_count: got %0d expected 6", seen); end
  endtask

  task automatic test_redirect_inflight;
    do_reset(3);
    repeat (6) next_cyc;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    mid;
    n_cmp++; if (imem_bus.req !== 1'b0) begin n_fail++; $display("FAIL rdi_req: got %b expected 0", imem_bus.req); end
    next_cyc;
    redirect_valid = 1'b0;
    mid;
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h100) begin n_fail++; $display("FAIL rdi_req1: got %b/%h expected 1/00000100", imem_bus.req, imem_bus.addr); end
    next_cyc; mid;
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h104) begin n_fail++; $display("FAIL rdi_req2: got %b/%h expected 1/00000104", imem_bus.req, imem_bus.addr); end
    for (int k = 7; k <= 12; k++) begin
      if (k > 8) begin next_cyc; mid; end
      if (k <= 10) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_stale[%0d]: got %b/%h expected 0", k, out_valid, out_pc); end
      end else begin
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(32'h100 + 4 * (k - 11)) || out_inst !== inst_of(32'(32'h100 + 4 * (k - 11)))) begin
          n_fail++; $display("FAIL rdi_target[%0d]: got %b/%h/%h expected 1/%h", k, out_valid, out_pc, out_inst, 32'(32'h100 + 4 * (k - 11)));
        end
      end
    end
  endtask

  task automatic test_redirect_fifo;
    do_reset(1);
    repeat (3) next_cyc;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    mid;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || imem_bus.req !== 1'b0) begin n_fail++; $display("FAIL rdf_cycle: got %b/%h req %b expected 1/00000004 req 0", out_valid, out_pc, imem_bus.req); end
    next_cyc;
    redirect_valid = 1'b0;
    mid;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdf_cleared: got %b expected 0", out_valid); end
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h100) begin n_fail++; $display("FAIL rdf_req: got %b/%h expected 1/00000100", imem_bus.req, imem_bus.addr); end
    next_cyc; mid;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdf_gap: got %b expected 0", out_valid); end
    for (int j = 0; j < 2; j++) begin
      next_cyc; mid;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(32'h100 + 4 * j)) begin n_fail++; $display("FAIL rdf_target[%0d]: got %b/%h expected 1/%h", j, out_valid, out_pc, 32'(32'h100 + 4 * j)); end
    end
  endtask

  task automatic test_redirect_stall;
    do_reset(1);
    repeat (4) next_cyc;
    stall = 1'b1;
    repeat (2) next_cyc;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    mid;
    n_cmp++; if (imem_bus.req !== 1'b0) begin n_fail++; $display("FAIL rds_req: got %b expected 0", imem_bus.req); end
    next_cyc;
    redirect_valid = 1'b0;
    mid;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rds_cleared: got %b expected 0", out_valid); end
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h200) begin n_fail++; $display("FAIL rds_addr: got %b/%h expected 1/00000200", imem_bus.req, imem_bus.addr); end
    repeat (2) next_cyc;
    mid;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin n_fail++; $display("FAIL rds_target: got %b/%h expected 1/00000200", out_valid, out_pc); end
    stall = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset(1);
    repeat (4) next_cyc;
    stall = 1'b1;
    next_cyc;
    mid;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin n_fail++; $display("FAIL ar_pre: got %b/%h expected 1/00000008", out_valid, out_pc); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== NOP) begin n_fail++; $display("FAIL ar_outs: got %b/%h/%h expected 0/00000000/%h", out_valid, out_pc, out_inst, NOP); end
    n_cmp++; if (imem_bus.req !== 1'b0) begin n_fail++; $display("FAIL ar_req: got %b expected 0", imem_bus.req); end
    repeat (2) @(posedge clk);
    #1 stall = 1'b0; reset_n = 1'b1;
    mid;
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin n_fail++; $display("FAIL ar_restart: got %b/%h expected 1/00000000", imem_bus.req, imem_bus.addr); end
    repeat (2) next_cyc;
    mid;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL ar_first: got %b/%h expected 1/00000000", out_valid, out_pc); end
    next_cyc; mid;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin n_fail++; $display("FAIL ar_second: got %b/%h expected 1/00000004", out_valid, out_pc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_bus.gnt       = 1'b1;
    imem_bus.rsp_valid = 1'b0;
    imem_bus.rsp_data  = 32'h0;
    test_reset;
    test_stream;
    test_stall;
    test_latency;
    test_redirect_inflight;
    test_redirect_fifo;
    test_redirect_stall;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
